// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                     |
// | Stall/flush/freeze sequencer for a 5-stage RISC-V pipeline.              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  ex_mem_br_taken,
  input  logic                  ex_mem_memaccess,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  pipe_freeze,
  output logic                  dmem_req,
  output logic                  mem_timeout_err,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [1:0] C_ST_RUN      = 2'd0;
  localparam logic [1:0] C_ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] C_ST_ERROR    = 2'd2;

  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              w_load_use;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_load_use = id_ex_memread && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) ||
                       (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    id_ex_bubble    = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    pipe_freeze     = 1'b0;
    dmem_req        = 1'b0;
    mem_timeout_err = 1'b0;
    w_flush_inc     = 1'b0;

    case (state_q)
      C_ST_RUN: begin
        if (ex_mem_br_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (ex_mem_memaccess) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_d     = C_ST_MEM_WAIT;
            wait_cnt_d  = C_WAIT_ONE;
          end
        end else if (w_load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      C_ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d    = C_ST_RUN;
          wait_cnt_d = '0;
        end else begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (wait_cnt_q == C_WAIT_MAX) state_d = C_ST_ERROR;
          else wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      C_ST_ERROR: begin
        pipe_freeze     = 1'b1;
        pc_write        = 1'b0;
        if_id_write     = 1'b0;
        mem_timeout_err = 1'b1;
      end
      default: begin
        state_d    = C_ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Reset overrides every output to the free-running, no-hazard pattern.
    if (reset) begin
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      id_ex_bubble    = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_flush    = 1'b0;
      pipe_freeze     = 1'b0;
      dmem_req        = 1'b0;
      mem_timeout_err = 1'b0;
      w_flush_inc     = 1'b0;
    end

    w_stall_inc   = !pc_write && (state_q == C_ST_RUN || state_q == C_ST_MEM_WAIT);
    stall_count_d = (w_stall_inc && (stall_count_q != '1)) ? stall_count_q + 1'b1 : stall_count_q;
    flush_count_d = (w_flush_inc && (flush_count_q != '1)) ? flush_count_q + 1'b1 : flush_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= C_ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl                                                  |
// | Scoreboard bench for pipeline_hazard_ctrl (narrow counters, short wait). |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int MWM  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] rs1, rs2, rd;
  logic uses_rs2, memread, br, macc, ready;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush;
  logic pipe_freeze, dmem_req, mem_timeout_err;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_WAIT_MAX(MWM)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(uses_rs2),
    .id_ex_rd(rd), .id_ex_memread(memread),
    .ex_mem_br_taken(br), .ex_mem_memaccess(macc), .dmem_ready(ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pipe_freeze(pipe_freeze), .dmem_req(dmem_req), .mem_timeout_err(mem_timeout_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // o = {pc_write, if_id_write, bubble, if_flush, id_flush, ex_flush, freeze, req, err}
  typedef struct packed {
    logic [8:0]    o;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: 0=RUN 1=MEM_WAIT 2=ERROR
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic lu;
    logic pcw, ifw, bub, f1, f2, f3, frz, req, err;
    lu  = memread && (rd != 0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    pcw = 1; ifw = 1; bub = 0; f1 = 0; f2 = 0; f3 = 0; frz = 0; req = 0; err = 0;
    if (!reset) begin
      if (m_state == 0) begin
        if (br) begin
          f1 = 1; f2 = 1; f3 = 1;
        end else if (macc) begin
          req = 1;
          if (!ready) begin frz = 1; pcw = 0; ifw = 0; end
        end else if (lu) begin
          pcw = 0; ifw = 0; bub = 1;
        end
      end else if (m_state == 1) begin
        req = 1;
        if (!ready) begin frz = 1; pcw = 0; ifw = 0; end
      end else begin
        frz = 1; pcw = 0; ifw = 0; err = 1;
      end
    end
    e.o  = {pcw, ifw, bub, f1, f2, f3, frz, req, err};
    e.sc = CW'(m_stall);
    e.fc = CW'(m_flush);
    return e;
  endfunction

  task automatic model_update();
    exp_t e;
    e = predict();
    if (reset) begin
      m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_state != 2 && !e.o[8] && m_stall < CMAX) m_stall++;
      if (m_state == 0 && br && m_flush < CMAX) m_flush++;
      case (m_state)
        0: if (!br && macc && !ready) begin m_state = 1; m_wait = 1; end
        1: begin
          if (ready) begin m_state = 0; m_wait = 0; end
          else if (m_wait == MWM) m_state = 2;
          else m_wait++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                      input logic [RW-1:0] d, input logic u, input logic mr,
                      input logic b, input logic ma, input logic rdy);
    exp_t e;
    @(negedge clk);
    reset = r; rs1 = a1; rs2 = a2; rd = d; uses_rs2 = u; memread = mr;
    br = b; macc = ma; ready = rdy;
    sb_q.push_back(predict());
    #1;
    e = sb_q.pop_front();
    chk("pc_write",     32'(pc_write),        32'(e.o[8]));
    chk("if_id_write",  32'(if_id_write),     32'(e.o[7]));
    chk("id_ex_bubble", 32'(id_ex_bubble),    32'(e.o[6]));
    chk("if_id_flush",  32'(if_id_flush),     32'(e.o[5]));
    chk("id_ex_flush",  32'(id_ex_flush),     32'(e.o[4]));
    chk("ex_mem_flush", 32'(ex_mem_flush),    32'(e.o[3]));
    chk("pipe_freeze",  32'(pipe_freeze),     32'(e.o[2]));
    chk("dmem_req",     32'(dmem_req),        32'(e.o[1]));
    chk("timeout_err",  32'(mem_timeout_err), 32'(e.o[0]));
    chk("stall_count",  32'(stall_count),     32'(e.sc));
    chk("flush_count",  32'(flush_count),     32'(e.fc));
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 2, 3, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; rs1 = 0; rs2 = 0; rd = 0; uses_rs2 = 0; memread = 0;
    br = 0; macc = 0; ready = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 5, 0, 1, 1, 1, 0);
    idle(1);

    // Load-use on rs1 and rs2, and the non-hazard corner cases
    step(0, 5, 0, 5, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 7, 7, 0, 1, 0, 0, 0);
    step(0, 1, 7, 7, 1, 1, 0, 0, 0);
    step(0, 5, 0, 5, 0, 0, 0, 0, 0);

    // Taken branch outranks a load-use match
    step(0, 5, 0, 5, 0, 1, 1, 0, 0);
    idle(1);

    // Memory access: 3 wait cycles then ready; then zero-wait access
    step(0, 5, 0, 5, 0, 1, 0, 1, 0);
    step(0, 5, 0, 5, 0, 1, 0, 1, 0);
    step(0, 5, 0, 5, 0, 1, 0, 1, 0);
    step(0, 5, 0, 5, 0, 1, 0, 1, 1);
    step(0, 5, 0, 5, 0, 1, 0, 0, 0);
    step(0, 1, 2, 3, 0, 0, 0, 1, 1);
    idle(1);

    // Timeout into ERROR, ERROR ignores everything, reset recovers
    for (int i = 0; i < 8; i++) step(0, 1, 2, 3, 0, 0, 0, 1, 0);
    step(0, 5, 0, 5, 0, 1, 1, 0, 1);
    step(0, 1, 2, 3, 0, 0, 0, 1, 1);
    step(1, 1, 2, 3, 0, 0, 0, 1, 0);
    idle(2);

    // Reset mid-MEM_WAIT
    step(0, 1, 2, 3, 0, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 0, 0, 1, 0);
    step(1, 1, 2, 3, 0, 0, 0, 1, 0);
    idle(1);

    // Counter saturation
    for (int i = 0; i < 20; i++) step(0, 9, 0, 9, 0, 1, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 1, 2, 3, 0, 0, 1, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional resets to escape ERROR
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
